adder_share_seq: RTL and testbench
==================================

// Module: adder_share_seq
// PURPOSE
//  Shares one combinational 8-bit adder slice (sum/carry from a full-adder chain) between two requesters.
//  Wide additions are run one byte per cycle, with the carry passed from each byte to the next.
//  Sits between the requesting engines and the shared adder, and owns the adder's input ports.
//  Round-robin arbitration; one operation in flight at a time.
// PARAMETERS
//  WORDS   4   bytes per operand; operand width W = 8*WORDS (WORDS >= 1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  req_valid  in   2      per-requester request valid; bit i = requester i
//  req_a      in   2*W    operand A, requester i at [i*W +: W]
//  req_b      in   2*W    operand B, same packing
//  req_ready  out  2      one-hot grant/accept; handshake when req_valid[i] & req_ready[i]
//  add_a      out  8      byte of A driven to shared adder
//  add_b      out  8      byte of B driven to shared adder
//  add_cin    out  1      carry into shared adder
//  add_sum    in   8      adder sum (combinational from add_a/add_b/add_cin)
//  add_cout   in   1      adder carry out
//  rsp_valid  out  1      result available
//  rsp_ready  in   1      consumer accepts result
//  rsp_sum    out  W+1    full sum; MSB = final carry
//  rsp_id     out  1      requester that owns rsp_sum
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, rr_ptr=0, byte_idx=0, carry=0.
//   All outputs 0: req_ready, rsp_valid, rsp_sum, rsp_id, add_a, add_b, add_cin.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE
//   - req_ready is combinational: one-hot to the granted requester, at most one bit set.
//   - Grant: if both are valid, grant rr_ptr; if one is valid, grant that one.
//   - On handshake: latch A, B and id; byte_idx=0; carry=0; go to RUN.
//   - rr_ptr toggles to the other requester only when a grant is made while both were valid.
//  RUN
//   - add_a/add_b = latched A/B byte[byte_idx]; add_cin = carry register.
//   - Each cycle: store add_sum into result byte[byte_idx]; carry <= add_cout; byte_idx++.
//   - After byte WORDS-1: result bit W <= add_cout; go to DONE.
//   - Exactly WORDS cycles in RUN. req_ready = 0.
//   - add_* are 0 in every state except RUN.
//  DONE
//   - rsp_valid=1; rsp_sum and rsp_id held stable until rsp_ready.
//   - On rsp_valid & rsp_ready: go to IDLE. A new grant can occur on the next cycle (no combinational bypass).
//  Latency: handshake at cycle t -> rsp_valid first asserted at t+WORDS+1.
//  Sum is unsigned and exact: rsp_sum = A + B, width W+1, no overflow loss.
//   Example: 0xFFFFFFFF + 1 = 0x1_0000_0000.
//  Request changes are ignored except in IDLE. Operands are captured at the handshake; later changes have no effect.
//  Back-pressure: rsp_ready low holds DONE indefinitely; no request is accepted meanwhile.
//  Reset mid-operation: aborts immediately. No response is produced; the in-flight request is lost; state returns to IDLE.
//  WORDS=1: RUN lasts exactly 1 cycle.
// TESTING
//  1. Single request: req0 A=0x000000AD, B=0x00000039, rsp_ready=1
//     -> rsp_valid at t+5; rsp_sum=0x0_000000E6; rsp_id=0.
//  2. Full carry ripple: A=0xFFFFFFFF, B=0x00000001
//     -> rsp_sum=0x1_00000000; add_cin=1 in RUN cycles 2-4.
//  3. Simultaneous requests, both held valid
//     -> grants alternate 0,1,0,1 across four transactions; never both req_ready bits set.
//  4. Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid
//     -> rsp_sum/rsp_id stable; req_ready=0 throughout; release -> IDLE next cycle.
//  5. Reset mid-RUN (assert rst in RUN cycle 2)
//     -> all outputs 0 immediately; no rsp_valid.
//     Next request after reset -> rsp_sum of the new operands only.
//  6. Random regression
//     -> 1000 random A/B/valid patterns; every response equals A+B of its requester, in grant order.

Source files
------------

// File: rtl/adder_share_seq_if.sv
// Request, response and shared-adder signal bundle for adder_share_seq.
// The arbiter is the slave of the requesters and consumer; the bench (or system) is the master.
interface adder_share_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 8 * WORDS;

  logic [1:0]     req_valid;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_ready;

  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic           add_cin;
  logic [7:0]     add_sum;
  logic           add_cout;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [W:0]     rsp_sum;
  logic           rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_sum, add_cout,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_sum, add_cout,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/adder_share_seq.sv
// Round-robin front end for one shared 8-bit adder slice: runs a WORDS-byte
// addition one byte per cycle, rippling the carry through a register.
module adder_share_seq #(
  parameter int WORDS = 4
) (
  input logic              clk,
  input logic              rst,
  adder_share_seq_if.slave bus
);
  localparam int W  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic          rr_ptr;
  logic [IW-1:0] byte_idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic          res_msb;
  logic          id_q;

  logic [1:0]    grant;
  logic          hs;
  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic          last_byte;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      if (bus.req_valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
      else                        grant = bus.req_valid;
    end
  end

  assign hs            = |(grant & bus.req_valid);
  assign bus.req_ready = grant;

  // Byte select for the current ripple step; a compare per byte keeps the mux
  // free of variable part-selects.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (byte_idx == IW'(k)) begin
        a_byte = a_q[k*8 +: 8];
        b_byte = b_q[k*8 +: 8];
      end
    end
  end

  assign last_byte   = (byte_idx == IW'(WORDS - 1));
  assign bus.add_a   = (state == RUN) ? a_byte : 8'h00;
  assign bus.add_b   = (state == RUN) ? b_byte : 8'h00;
  assign bus.add_cin = (state == RUN) & carry;

  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_sum   = {res_msb, res_q};
  assign bus.rsp_id    = id_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand and result registers are reset as well, so rsp_sum and rsp_id read 0 after any reset.
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      byte_idx <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      res_msb  <= 1'b0;
      id_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            id_q     <= grant[1];
            a_q      <= grant[1] ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
            b_q      <= grant[1] ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
            byte_idx <= '0;
            carry    <= 1'b0;
            if (bus.req_valid == 2'b11) rr_ptr <= ~rr_ptr;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (byte_idx == IW'(k)) res_q[k*8 +: 8] <= bus.add_sum;
          end
          carry <= bus.add_cout;
          if (last_byte) begin
            res_msb  <= bus.add_cout;
            byte_idx <= '0;
            state    <= DONE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_seq.sv
// Bench for adder_share_seq: an abstract phase/arithmetic model checks every
// output on each falling edge; directed tests pin the model with literals.
module tb_adder_share_seq;
  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  typedef struct {
    logic [W:0] sum;
    logic       id;
    int         lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_share_seq_if #(.WORDS(WORDS)) bus ();

  adder_share_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // The shared adder slice the block drives.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the block must be doing, derived from the rules alone.
  mphase_t          m_phase = M_IDLE;
  logic             m_rr    = 1'b0;
  int               m_cnt   = 0;
  logic [W-1:0]     m_a, m_b;
  logic             m_id;
  logic [WORDS-1:0] m_cin_hist;
  int               m_lat;
  bit               m_lat_seen;
  int               cyc     = 0;
  int               hs_cyc  = 0;
  int               grant_log[$];
  rsp_t             rsp_log[$];

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    if (v == 2'b11) return m_rr ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Carry into byte c is the carry out of the low c bytes added exactly.
  function automatic logic carry_into(input int c);
    logic [W:0] mask, s;
    if (c == 0) return 1'b0;
    mask = ((W+1)'(1) << (8*c)) - 1'b1;
    s    = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask);
    return s[8*c];
  endfunction

  always @(negedge clk) begin
    logic [1:0]   g;
    logic [W-1:0] sa, sb;
    cyc++;
    if (rst) begin
      check("rst_req_ready", 64'(bus.req_ready), 0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 0);
      check("rst_rsp_sum",   64'(bus.rsp_sum),   0);
      check("rst_rsp_id",    64'(bus.rsp_id),    0);
      check("rst_add_a",     64'(bus.add_a),     0);
      check("rst_add_b",     64'(bus.add_b),     0);
      check("rst_add_cin",   64'(bus.add_cin),   0);
      m_phase = M_IDLE;
      m_rr    = 1'b0;
      m_cnt   = 0;
    end else begin
      g = model_grant(bus.req_valid);
      case (m_phase)
        M_IDLE: begin
          check("idle_req_ready", 64'(bus.req_ready), 64'(g));
          check("idle_rsp_valid", 64'(bus.rsp_valid), 0);
          check("idle_add",       64'({bus.add_a, bus.add_b, bus.add_cin}), 0);
          if (g != 2'b00) begin
            m_id = g[1];
            m_a  = g[1] ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
            m_b  = g[1] ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
            if (bus.req_valid == 2'b11) m_rr = ~m_rr;
            grant_log.push_back(int'(m_id));
            hs_cyc     = cyc;
            m_cnt      = 0;
            m_lat_seen = 1'b0;
            m_phase    = M_RUN;
          end
        end
        M_RUN: begin
          sa = m_a >> (8*m_cnt);
          sb = m_b >> (8*m_cnt);
          check("run_req_ready", 64'(bus.req_ready), 0);
          check("run_rsp_valid", 64'(bus.rsp_valid), 0);
          check("run_add_a",     64'(bus.add_a),     64'(sa[7:0]));
          check("run_add_b",     64'(bus.add_b),     64'(sb[7:0]));
          check("run_add_cin",   64'(bus.add_cin),   64'(carry_into(m_cnt)));
          m_cin_hist[m_cnt] = bus.add_cin;
          m_cnt++;
          if (m_cnt == WORDS) m_phase = M_DONE;
        end
        M_DONE: begin
          if (!m_lat_seen) begin
            m_lat      = cyc - hs_cyc;
            m_lat_seen = 1'b1;
          end
          check("done_req_ready", 64'(bus.req_ready), 0);
          check("done_rsp_valid", 64'(bus.rsp_valid), 1);
          check("done_rsp_sum",   64'(bus.rsp_sum),   64'({1'b0, m_a}) + 64'({1'b0, m_b}));
          check("done_rsp_id",    64'(bus.rsp_id),    64'(m_id));
          check("done_add",       64'({bus.add_a, bus.add_b, bus.add_cin}), 0);
          if (bus.rsp_ready) begin
            rsp_log.push_back('{sum: bus.rsp_sum, id: bus.rsp_id, lat: m_lat});
            m_phase = M_IDLE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int n  = grant_log.size();
    bit ok = 1'b0;
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_valid[id]    = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = (grant_log.size() > n);
    end
    bus.req_valid[id] = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (rsp_log.size() > n);
    end
    if (!ok) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n, g0;
    bit ok;
    // NOTE: the bench drives DUT inputs with blocking assignments, shortly after the rising edge.
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    rst           = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: single request, latency and exact sum
    n = rsp_log.size();
    send(0, 32'h0000_00AD, 32'h0000_0039);
    wait_rsp(n);
    check("t1_sum", 64'(rsp_log[n].sum), 64'h0_0000_00E6);
    check("t1_id",  64'(rsp_log[n].id),  0);
    check("t1_lat", 64'(rsp_log[n].lat), 5);
    check("t1_cin", 64'(m_cin_hist),     64'b0000);

    // 2: carry ripples through every byte
    n = rsp_log.size();
    send(0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_rsp(n);
    check("t2_sum", 64'(rsp_log[n].sum), 64'h1_0000_0000);
    check("t2_cin", 64'(m_cin_hist),     64'b1110);

    // 3: both requesters held valid alternate grants
    n  = rsp_log.size();
    g0 = grant_log.size();
    bus.req_a     = {32'h2222_2222, 32'h1111_1111};
    bus.req_b     = {32'h0000_0002, 32'h0000_0001};
    bus.req_valid = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (grant_log.size() >= g0 + 4) begin
        bus.req_valid = 2'b00;
        ok = 1'b1;
      end
    end
    bus.req_valid = 2'b00;
    check("t3_grants_made", 64'(ok), 1);
    if (ok) begin
      wait_rsp(n + 3);
      for (int k = 0; k < 4; k++) begin
        check("t3_grant_order", 64'(grant_log[g0+k]), 64'(k % 2));
        if (rsp_log.size() > n + k) begin
          check("t3_sum", 64'(rsp_log[n+k].sum), (k % 2 == 0) ? 64'h1111_1112 : 64'h2222_2224);
          check("t3_id",  64'(rsp_log[n+k].id),  64'(k % 2));
        end
      end
    end

    // 4: back-pressure holds the response and blocks new grants
    bus.rsp_ready = 1'b0;
    n = rsp_log.size();
    send(1, 32'h1234_5678, 32'h0F0F_0F0F);
    bus.req_a     = {32'h0000_0005, 32'h0000_0001};
    bus.req_b     = {32'h0000_0006, 32'h0000_0002};
    bus.req_valid = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = bus.rsp_valid;
    end
    check("t4_reach_done", 64'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_valid", 64'(bus.rsp_valid), 1);
      check("t4_hold_sum",   64'(bus.rsp_sum),   64'h0_2143_6587);
      check("t4_hold_id",    64'(bus.rsp_id),    1);
      check("t4_no_ready",   64'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("t4_release_idle", 64'(bus.req_ready), 64'b01);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(n + 1);
    if (rsp_log.size() > n + 1) begin
      check("t4_next_sum", 64'(rsp_log[n+1].sum), 64'h3);
      check("t4_next_id",  64'(rsp_log[n+1].id),  0);
    end

    // 5: reset in the second RUN cycle aborts the operation
    n = rsp_log.size();
    send(0, 32'hAAAA_AAAA, 32'h5555_5555);
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("t5_req_ready", 64'(bus.req_ready), 0);
    check("t5_rsp_valid", 64'(bus.rsp_valid), 0);
    check("t5_rsp_sum",   64'(bus.rsp_sum),   0);
    check("t5_add",       64'({bus.add_a, bus.add_b, bus.add_cin}), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_rsp", 64'(rsp_log.size()), 64'(n));
    send(1, 32'h0000_0010, 32'h0000_0020);
    wait_rsp(n);
    check("t5_new_sum", 64'(rsp_log[$].sum), 64'h30);
    check("t5_new_id",  64'(rsp_log[$].id),  1);
    check("t5_one_rsp", 64'(rsp_log.size()), 64'(n + 1));

    // 6: random traffic, every output checked by the model each cycle
    n = rsp_log.size();
    for (int i = 0; i < 1000; i++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_a     = {$urandom, $urandom};
      bus.req_b     = {$urandom, $urandom};
      if (i % 9 == 0) bus.req_a = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (WORDS + 4) tick();
    check("t6_activity", 64'(rsp_log.size() - n > 50), 1);
    check("t6_drained",  64'(bus.rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
